// File: rtl/aes_ahb_master.sv
// AHB-Lite initiator for the AES accelerator: writes an optional key and a plaintext block,
// then reads the ciphertext back as 32-bit single transfers with wait-state and error handling.
module aes_ahb_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         load_key,
    input  logic [127:0] key,
    input  logic [127:0] block_in,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] block_out,
    output logic [31:0]  HADDR,
    output logic [1:0]   HTRANS,
    output logic         HWRITE,
    output logic [2:0]   HSIZE,
    output logic [31:0]  HWDATA,
    input  logic [31:0]  HRDATA,
    input  logic         HREADY,
    input  logic         HRESP
);

    localparam int             WW        = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0]  TIMEOUT_W = WW'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_FIN, S_ERR} state_t;

    state_t        state, state_nx;
    logic [127:0]  key_q, blk_q;
    logic [3:0]    beat;
    logic [WW-1:0] wait_cnt;
    logic          error_q;
    logic          in_xfer, is_write;
    logic [31:0]   cur_word;

    // Big-endian word order: index 0 is bits [127:96].
    function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    return v[127:96];
            2'd1:    return v[95:64];
            2'd2:    return v[63:32];
            default: return v[31:0];
        endcase
    endfunction

    assign in_xfer  = (state == S_ADDR) || (state == S_DATA);
    assign is_write = (beat < 4'd8);
    assign cur_word = (beat < 4'd4) ? word_of(key_q, beat[1:0]) : word_of(blk_q, beat[1:0]);

    // NOTE: always_comb assigns every output a default first so no latch can be inferred.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_ADDR;
            S_ADDR: state_nx = S_DATA;
            S_DATA: begin
                if (HRESP)                        state_nx = S_ERR;
                else if (HREADY)                  state_nx = (beat == 4'd11) ? S_FIN : S_ADDR;
                else if (wait_cnt == TIMEOUT_W)   state_nx = S_ERR;
            end
            S_FIN:   state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            key_q     <= '0;
            blk_q     <= '0;
            beat      <= '0;
            wait_cnt  <= '0;
            error_q   <= 1'b0;
            block_out <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                key_q    <= key;
                blk_q    <= block_in;
                beat     <= load_key ? 4'd0 : 4'd4;
                wait_cnt <= '0;
                error_q  <= 1'b0;
            end
            if (state == S_DATA && !HRESP) begin
                if (HREADY) begin
                    wait_cnt <= '0;
                    if (!is_write) begin
                        case (beat[1:0])
                            2'd0:    block_out[127:96] <= HRDATA;
                            2'd1:    block_out[95:64]  <= HRDATA;
                            2'd2:    block_out[63:32]  <= HRDATA;
                            default: block_out[31:0]   <= HRDATA;
                        endcase
                    end
                    if (beat != 4'd11) beat <= beat + 4'd1;
                end else if (wait_cnt != TIMEOUT_W) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
            if (state_nx == S_ERR) error_q <= 1'b1;
        end
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_FIN) || (state == S_ERR);
    assign error  = error_q;
    // Address phase is dropped combinationally so a reset never leaves a NONSEQ on the bus.
    assign HTRANS = (state == S_ADDR && !rst) ? 2'b10 : 2'b00;
    assign HADDR  = in_xfer ? BASE_ADDR + {26'd0, beat, 2'b00} : 32'h0;
    assign HWRITE = in_xfer && is_write;
    assign HSIZE  = 3'b010;
    assign HWDATA = (state == S_DATA && is_write) ? cur_word : 32'h0;

endmodule

// File: tb/tb_aes_ahb_master.sv
// Scoreboard bench for aes_ahb_master: a small AHB slave model answers the bus, stimulus
// queues expected beats and completions, and a monitor compares them as the DUT produces them.
module tb_aes_ahb_master;

    localparam logic [127:0] KEY0   = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] PT0    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] EXP_CT = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;

    logic         clk = 1'b0;
    logic         rst, start, load_key, start2;
    logic [127:0] key, block_in;
    logic         busy, done, error;
    logic [127:0] block_out;
    logic [31:0]  HADDR, HWDATA, HRDATA;
    logic [1:0]   HTRANS;
    logic         HWRITE, HREADY, HRESP;
    logic [2:0]   HSIZE;

    logic         busy2, done2, error2, hwrite2, hready2;
    logic [127:0] block_out2;
    logic [31:0]  haddr2, hwdata2;
    logic [1:0]   htrans2;
    logic [2:0]   hsize2;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_ahb_master dut (
        .clk(clk), .rst(rst), .start(start), .load_key(load_key), .key(key), .block_in(block_in),
        .busy(busy), .done(done), .error(error), .block_out(block_out),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    aes_ahb_master #(.TIMEOUT(16)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .load_key(load_key), .key(key), .block_in(block_in),
        .busy(busy2), .done(done2), .error(error2), .block_out(block_out2),
        .HADDR(haddr2), .HTRANS(htrans2), .HWRITE(hwrite2), .HSIZE(hsize2), .HWDATA(hwdata2),
        .HRDATA(32'h0), .HREADY(hready2), .HRESP(1'b0)
    );

    // Slave model for the main DUT: optional stall on one address, optional error on another.
    logic        dphase, dwrite;
    logic [31:0] daddr, stall_addr, err_addr;
    int          stall_cnt, stall_len;
    logic        err_en;
    logic [31:0] res_words [4];

    initial begin
        res_words[0] = 32'h69C4E0D8;
        res_words[1] = 32'h6A7B0430;
        res_words[2] = 32'hD8CDB780;
        res_words[3] = 32'h70B4C55A;
    end

    always @(posedge clk) begin
        if (rst) begin
            dphase    <= 1'b0;
            stall_cnt <= 0;
        end else if (HTRANS == 2'b10) begin
            dphase    <= 1'b1;
            daddr     <= HADDR;
            dwrite    <= HWRITE;
            stall_cnt <= 0;
        end else if (dphase && (HREADY || HRESP)) begin
            dphase <= 1'b0;
        end else if (dphase) begin
            stall_cnt <= stall_cnt + 1;
        end
    end

    assign HRESP  = dphase && err_en && (daddr == err_addr);
    assign HREADY = !dphase ? 1'b1 : HRESP ? 1'b0 : !((daddr == stall_addr) && (stall_cnt < stall_len));
    assign HRDATA = (dphase && daddr >= 32'h20 && daddr < 32'h30) ? res_words[daddr[3:2]] : 32'hDEAD_BEEF;

    // Slave for the TIMEOUT=16 instance: never ready once a result address is in data phase.
    logic [31:0] addr2_q;
    always @(posedge clk) begin
        if (rst)                  addr2_q <= 32'h0;
        else if (htrans2 == 2'b10) addr2_q <= haddr2;
    end
    assign hready2 = (addr2_q < 32'h20);

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        int           cyc;
        logic         err;
        logic         chk_blk;
        logic [127:0] blk;
    } done_t;

    beat_t exp_beats [$];
    done_t exp_done  [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] word(input logic [127:0] v, input int n);
        return v[127 - 32*(n % 4) -: 32];
    endfunction

    // Monitor: pops expected beats on each address phase and expected completions on done.
    beat_t cur;
    logic  cur_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (HTRANS == 2'b10) begin
                if (exp_beats.size() == 0) fail_now("unexpected_addr_phase");
                else begin
                    cur       = exp_beats.pop_front();
                    cur_valid = 1'b1;
                    check("beat_haddr", HADDR, cur.addr);
                    check("beat_hwrite", HWRITE, cur.write);
                end
            end
            if (dphase && dwrite && HREADY && cur_valid) check("beat_hwdata", HWDATA, cur.wdata);
            if (done) begin
                if (exp_done.size() == 0) fail_now("unexpected_done");
                else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("done_error", error, d.err);
                    check("done_busy", busy, 1'b1);
                    if (d.chk_blk) check("block_out", block_out, d.blk);
                end
            end
        end
    end

    task automatic issue(input logic lk, input logic [127:0] k, input logic [127:0] b,
                         input int waits, input int err_beat, output int t);
        int    first, last;
        beat_t e;
        done_t d;
        first = lk ? 0 : 4;
        last  = (err_beat >= 0) ? err_beat : 11;
        for (int n = first; n <= last; n++) begin
            e.addr  = 32'(4 * n);
            e.write = (n < 8);
            e.wdata = (n < 4) ? word(k, n) : (n < 8) ? word(b, n) : 32'h0;
            exp_beats.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b1; load_key = lk; key = k; block_in = b;
        t = cyc;
        d.cyc     = t + 2*(last - first + 1) + 1 + waits;
        d.err     = (err_beat >= 0);
        d.chk_blk = (err_beat < 0);
        d.blk     = EXP_CT;
        exp_done.push_back(d);
        @(posedge clk); #1;
        start = 1'b0;
        key = ~k; block_in = ~b; load_key = ~lk;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) fail_now({name, "_done_timeout"});
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_htrans"}, HTRANS, 2'b00);
        check({tag, "_haddr"}, HADDR, 32'h0);
        check({tag, "_hwrite_hwdata"}, {HWRITE, HWDATA}, 33'h0);
        check({tag, "_hsize"}, HSIZE, 3'b010);
        check({tag, "_busy_done_error"}, {busy, done, error}, 3'b000);
        check({tag, "_block_out"}, block_out, 128'h0);
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; load_key = 1'b0;
        key = '0; block_in = '0;
        stall_addr = 32'hFFFF_FFFF; stall_len = 0; err_addr = 32'hFFFF_FFFF; err_en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Full request with key, zero-wait slave.
        issue(1'b1, KEY0, PT0, 0, -1, t);
        check("busy_after_start", busy, 1'b1);
        wait_done("full_key");
        check("busy_low_after_done", {busy, done}, 2'b00);

        // Plaintext only.
        issue(1'b0, 128'hA5A5_A5A5_0000_1111_2222_3333_4444_5555, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, -1, t);
        wait_done("no_key");

        // Result beat 8 held for 30 wait states.
        stall_addr = 32'h20; stall_len = 30;
        issue(1'b1, KEY0, PT0, 30, -1, t);
        wait_done("stall");
        stall_len = 0;

        // Error response on beat 5.
        err_addr = 32'h14; err_en = 1'b1;
        issue(1'b1, KEY0, PT0, 0, 5, t);
        wait_done("hresp");
        err_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("error_held", {error, busy}, 2'b10);
        issue(1'b0, KEY0, PT0, 0, -1, t);
        check("error_cleared_on_start", error, 1'b0);
        wait_done("after_error");

        // Reset during beat 6 data phase, then a clean restart with a start pulse while busy.
        issue(1'b1, KEY0, PT0, 0, -1, t);
        while (cyc < t + 14) begin
            @(posedge clk); #1;
        end
        check("beat6_data_phase", {HADDR, HWRITE, HTRANS}, {32'h18, 1'b1, 2'b00});
        rst = 1'b1;
        @(posedge clk); #1;
        exp_beats.delete();
        exp_done.delete();
        check_reset_outputs("midrst");
        rst = 1'b0;
        issue(1'b1, KEY0, PT0, 0, -1, t);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; load_key = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("after_rst");

        check("scoreboard_beats_drained", exp_beats.size(), 0);
        check("scoreboard_done_drained", exp_done.size(), 0);

        // Timeout on the TIMEOUT=16 instance: result beat 8 never completes.
        @(posedge clk); #1;
        start2 = 1'b1; load_key = 1'b1; key = KEY0; block_in = PT0;
        t = cyc;
        @(posedge clk); #1;
        start2 = 1'b0;
        begin
            int k = 0;
            while (done2 !== 1'b1 && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (k >= 200) fail_now("timeout_done_missing");
        end
        check("timeout_done_cycle", cyc, t + 35);
        check("timeout_flags", {done2, error2, busy2}, 3'b111);
        @(posedge clk); #1;
        check("timeout_after", {done2, error2, busy2}, 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
